// File: rtl/piso_tx_arbiter.sv
// Round-robin arbiter feeding one shared PISO shift register; words leave LSB-first
// with a done pulse on the last bit and optional idle gap between frames.
module piso_tx_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2,
    parameter int GAP   = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NREQ-1:0]           i_req_valid,
    input  logic [NREQ*WIDTH-1:0]     i_req_data,
    output logic [NREQ-1:0]           o_req_ready,
    input  logic                      i_hold,
    output logic                      o_sout,
    output logic                      o_sout_valid,
    output logic [$clog2(NREQ)-1:0]   o_src_id,
    output logic                      o_done,
    output logic                      o_busy,
    output logic [1:0]                o_state
);

    localparam int IDW = $clog2(NREQ);
    localparam int BW  = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shreg;
    logic [BW-1:0]    r_bitcnt;
    logic [3:0]       r_gapcnt;
    logic [IDW-1:0]   r_rr_last;
    logic [IDW-1:0]   r_src_id;

    logic             w_found;
    logic [IDW-1:0]   w_grant;
    logic [WIDTH-1:0] w_grant_data;
    logic             w_accept;
    logic             w_last_bit;
    logic             w_gap_end;

    // Handshake: word i transfers on the cycle where i_req_valid[i] & o_req_ready[i];
    // ready is offered only in IDLE with hold low, so a transfer always starts a frame.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        // Lowest valid index overall is the wrap-around fallback; the second pass
        // overrides it with the lowest valid index above the last winner.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req_valid[i]) begin
                w_found = 1'b1;
                w_grant = IDW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req_valid[i] && (i > int'(r_rr_last))) begin
                w_grant = IDW'(i);
            end
        end
    end

    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == w_grant) begin
                w_grant_data = i_req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_accept   = (r_state == S_IDLE) && !i_hold && w_found;
    assign w_last_bit = (r_state == S_SHIFT) && !i_hold && (r_bitcnt == LAST_BIT);
    assign w_gap_end  = (r_state == S_GAP) && (r_gapcnt == GAP_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)   w_next = S_SHIFT;
            S_SHIFT: if (w_last_bit) w_next = (GAP > 0) ? S_GAP : S_IDLE;
            S_GAP:   if (w_gap_end)  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shreg   <= '0;
            r_bitcnt  <= '0;
            r_gapcnt  <= '0;
            r_rr_last <= IDW'(NREQ - 1);
            r_src_id  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shreg   <= w_grant_data;
                        r_src_id  <= w_grant;
                        r_rr_last <= w_grant;
                        r_bitcnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    if (!i_hold) begin
                        r_shreg  <= r_shreg >> 1;
                        r_bitcnt <= w_last_bit ? '0 : r_bitcnt + 1'b1;
                        r_gapcnt <= '0;
                    end
                end
                S_GAP: begin
                    r_gapcnt <= r_gapcnt + 1'b1;
                end
                default: begin
                    r_gapcnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        o_req_ready  = w_accept ? (NREQ'(1) << w_grant) : '0;
        o_sout       = (r_state == S_SHIFT) && r_shreg[0];
        o_sout_valid = (r_state == S_SHIFT) && !i_hold;
        o_done       = w_last_bit;
        o_busy       = (r_state != S_IDLE);
        o_src_id     = r_src_id;
        o_state      = r_state;
    end

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Bench for piso_tx_arbiter: per-cycle vector table, round-robin and GAP sequences,
// and a scoreboard of expected {src_id, bit} pairs for the serial stream.
module tb_piso_tx_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance, GAP=0
    logic       rst, hold;
    logic [1:0] valid;
    logic [3:0] d0, d1;
    logic [1:0] ready;
    logic       sout, sv, src, done, busy;
    logic [1:0] state;

    // second instance, GAP=2
    logic       g_rst, g_hold;
    logic [1:0] g_valid;
    logic [3:0] g_d0, g_d1;
    logic [1:0] g_ready;
    logic       g_sout, g_sv, g_src, g_done, g_busy;
    logic [1:0] g_state;

    piso_tx_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .GAP(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .i_req_data({d1, d0}),
        .o_req_ready(ready), .i_hold(hold), .o_sout(sout), .o_sout_valid(sv),
        .o_src_id(src), .o_done(done), .o_busy(busy), .o_state(state)
    );

    piso_tx_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .GAP(2)) dut_gap (
        .i_clk(clk), .i_rst(g_rst), .i_req_valid(g_valid), .i_req_data({g_d1, g_d0}),
        .o_req_ready(g_ready), .i_hold(g_hold), .o_sout(g_sout), .o_sout_valid(g_sv),
        .o_src_id(g_src), .o_done(g_done), .o_busy(g_busy), .o_state(g_state)
    );

    int errors = 0;
    int checks = 0;
    logic [1:0] exp_q[$];

    // ins = {rst, hold, valid[1:0]}, exp = {ready[1:0], sout, sout_valid, src_id, done, busy}
    typedef struct {
        logic [3:0] ins;
        logic [6:0] exp;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] ins, input logic [6:0] exp);
        vec_t v;
        v.ins = ins;
        v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic s, input logic [3:0] word);
        for (int i = 0; i < WIDTH; i++) exp_q.push_back({s, word[2'(i)]});
    endtask

    task automatic sb_sample();
        logic [1:0] e;
        if (sv === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra_bit: got src=%0b bit=%0b expected no bit at %0t", src, sout, $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_bit", 16'({src, sout}), 16'(e));
            end
        end
    endtask

    initial begin
        logic [15:0] act, exp;
        logic [1:0]  e_rd;
        logic [3:0]  g_word;
        logic        e_sv, e_sout;
        int          p;

        rst = 1'b1; hold = 1'b0; valid = 2'b00; d0 = 4'hB; d1 = 4'h6;
        g_rst = 1'b1; g_hold = 1'b0; g_valid = 2'b00; g_d0 = 4'hB; g_d1 = 4'h0;
        repeat (2) @(posedge clk);
        #1;

        // Frame 1011 from req0, then the same frame with a 2-cycle hold, then hold in IDLE
        // against req1 (0110), then reset on bit2 of that frame.
        vecs.push_back(mk(4'b1000, 7'b00_0_0_0_0_0));
        vecs.push_back(mk(4'b0001, 7'b01_0_0_0_0_0));
        vecs.push_back(mk(4'b0000, 7'b00_1_1_0_0_1));
        vecs.push_back(mk(4'b0000, 7'b00_1_1_0_0_1));
        vecs.push_back(mk(4'b0000, 7'b00_0_1_0_0_1));
        vecs.push_back(mk(4'b0000, 7'b00_1_1_0_1_1));
        vecs.push_back(mk(4'b0000, 7'b00_0_0_0_0_0));
        vecs.push_back(mk(4'b0001, 7'b01_0_0_0_0_0));
        vecs.push_back(mk(4'b0000, 7'b00_1_1_0_0_1));
        vecs.push_back(mk(4'b0000, 7'b00_1_1_0_0_1));
        vecs.push_back(mk(4'b0100, 7'b00_0_0_0_0_1));
        vecs.push_back(mk(4'b0100, 7'b00_0_0_0_0_1));
        vecs.push_back(mk(4'b0000, 7'b00_0_1_0_0_1));
        vecs.push_back(mk(4'b0000, 7'b00_1_1_0_1_1));
        vecs.push_back(mk(4'b0000, 7'b00_0_0_0_0_0));
        vecs.push_back(mk(4'b0110, 7'b00_0_0_0_0_0));
        vecs.push_back(mk(4'b0110, 7'b00_0_0_0_0_0));
        vecs.push_back(mk(4'b0010, 7'b10_0_0_0_0_0));
        vecs.push_back(mk(4'b0000, 7'b00_0_1_1_0_1));
        vecs.push_back(mk(4'b0000, 7'b00_1_1_1_0_1));
        vecs.push_back(mk(4'b1000, 7'b00_1_1_1_0_1));
        vecs.push_back(mk(4'b0000, 7'b00_0_0_0_0_0));

        foreach (vecs[k]) begin
            {rst, hold, valid} = vecs[k].ins;
            if (vecs[k].exp[6:5] != 2'b00)
                push_word(vecs[k].exp[6], vecs[k].exp[6] ? d1 : d0);
            @(negedge clk);
            sb_sample();
            act = 16'({ready, sout, sv, src, done, busy});
            exp = 16'(vecs[k].exp);
            // sout is a don't-care while a frame is paused
            if (!(vecs[k].exp[3] || !vecs[k].exp[0])) act[4] = exp[4];
            check($sformatf("vec%0d", k), act, exp);
            if (vecs[k].ins[3]) exp_q.delete();
            @(posedge clk);
            #1;
        end

        // Both requesters held valid right after reset: grants 0,1,0,1 every 5 cycles.
        d0 = 4'hA; d1 = 4'h5; valid = 2'b11; hold = 1'b0; rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            e_rd = (c % 5 != 0) ? 2'b00 : (((c / 5) % 2 == 1) ? 2'b10 : 2'b01);
            if (e_rd != 2'b00) push_word(e_rd[1], e_rd[1] ? d1 : d0);
            @(negedge clk);
            sb_sample();
            check($sformatf("rr_c%0d", c), 16'({ready, done, busy}),
                  16'({e_rd, (c % 5 == 4), (c % 5 != 0)}));
            @(posedge clk);
            #1;
        end
        valid = 2'b00;
        @(negedge clk);
        sb_sample();
        check("rr_idle", 16'({ready, busy}), 16'd0);
        check("sb_empty", 16'(exp_q.size()), 16'd0);
        @(posedge clk);
        #1;

        // GAP=2 instance, req0 always valid: 7-cycle frame period.
        g_rst = 1'b0;
        g_valid = 2'b01;
        g_word = 4'hB;
        for (int c = 0; c < 14; c++) begin
            p = c % 7;
            e_sv = (p >= 1) && (p <= 4);
            e_sout = e_sv ? g_word[2'(p - 1)] : 1'b0;
            @(negedge clk);
            check($sformatf("gap_c%0d", c),
                  16'({g_ready, (e_sv ? g_sout : 1'b0), g_sv, g_done, g_busy}),
                  16'({(p == 0) ? 2'b01 : 2'b00, e_sout, e_sv, (p == 4), (p != 0)}));
            @(posedge clk);
            #1;
        end
        g_valid = 2'b00;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
